// File: rtl/melody_if.sv
// -----------------------------------------------------------------------------
// melody_if
//
// Purpose: groups the control and status signals of melody_player so that a
// controller (or bench) and the player connect through one bundle.
//
// Signals:
//   start     : request to begin playback, sampled on the rising clock edge
//   stop      : abort request, sampled on the rising clock edge, wins over start
//   ch_out    : square-wave audio output (registered)
//   busy      : high while a melody is playing (note or inter-note gap)
//   note_idx  : index of the current period-table entry
//   done      : one-cycle pulse at melody end
//   state_dbg : current FSM state (0 = IDLE, 1 = PLAY, 2 = GAP)
//
// Handshake: start and stop are level requests with no acknowledge. The player
// samples them on each rising edge. A start seen while busy is dropped. A stop
// seen while busy takes effect on that same edge. When both are high, stop wins.
//
// Modports:
//   master : the side that drives start/stop and observes status
//   slave  : the player itself
// -----------------------------------------------------------------------------
interface melody_if;
    logic       start;
    logic       stop;
    logic       ch_out;
    logic       busy;
    logic [2:0] note_idx;
    logic       done;
    logic [1:0] state_dbg;

    modport master (
        output start,
        output stop,
        input  ch_out,
        input  busy,
        input  note_idx,
        input  done,
        input  state_dbg
    );

    modport slave (
        input  start,
        input  stop,
        output ch_out,
        output busy,
        output note_idx,
        output done,
        output state_dbg
    );
endinterface

// File: rtl/melody_player.sv
// -----------------------------------------------------------------------------
// melody_player
//
// Purpose: plays the first LEN notes of a fixed 8-entry scale as a square wave.
// Each note sounds for DUR clocks and is followed by GAP clocks of silence.
// GAP = 0 means the next note follows at once. At the end of the melody, done
// pulses for one cycle and the player returns to IDLE.
//
// Parameters:
//   DUR : note length in clk cycles (2 .. 2^24-1)
//   GAP : silence after each note in clk cycles (0 .. 2^24-1)
//   LEN : number of table entries played (1 .. 8)
//
// Ports:
//   clk  : system clock (12 MHz board clock)
//   rstn : asynchronous active-low reset
//   bus  : melody_if.slave (start, stop in; ch_out, busy, note_idx, done,
//          state_dbg out)
//
// Configuration macro:
//   MELODY_LOOP_EN : when defined, the melody end pulses done, rewinds to note 0
//                    and keeps playing until stop or reset. When undefined,
//                    playback is single-shot.
//
// All outputs are taken straight from flops. The next-state logic also
// computes the next value of every output, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module melody_player #(
    parameter int unsigned DUR = 12000000,
    parameter int unsigned GAP = 600000,
    parameter int unsigned LEN = 8
) (
    input  logic     clk,
    input  logic     rstn,
    melody_if.slave  bus
);

    // Tone periods in clk cycles at 12 MHz (clk / note frequency). The names
    // and values match the board's divider.vh.
    localparam logic [15:0] DO_4  = 16'd45872;
    localparam logic [15:0] RE_4  = 16'd40863;
    localparam logic [15:0] MI_4  = 16'd36404;
    localparam logic [15:0] FA_4  = 16'd34361;
    localparam logic [15:0] SOL_4 = 16'd30612;
    localparam logic [15:0] LA_4  = 16'd27273;
    localparam logic [15:0] SI_4  = 16'd24297;
    localparam logic [15:0] DO_5  = 16'd22933;

    // Terminal counts for the shared segment counter. GAP_M1 is used only
    // when GAP is non-zero.
    localparam logic [23:0] DUR_M1   = 24'(DUR - 1);
    localparam logic [23:0] GAP_M1   = 24'(GAP - 1);
    localparam logic [2:0]  LAST_IDX = 3'(LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Period table lookup. An entry of 0 would be a rest: the wrap logic keeps
    // the period counter at 0 and ch_out stays low.
    function automatic logic [15:0] period_of(input logic [2:0] idx);
        logic [15:0] p;
        case (idx)
            3'd0:    p = DO_4;
            3'd1:    p = RE_4;
            3'd2:    p = MI_4;
            3'd3:    p = FA_4;
            3'd4:    p = SOL_4;
            3'd5:    p = LA_4;
            3'd6:    p = SI_4;
            default: p = DO_5;
        endcase
        return p;
    endfunction

    // Registered state.
    state_t      state_q;
    logic [2:0]  note_q;
    logic [23:0] dur_q;     // cycles spent in the current PLAY or GAP segment
    logic [15:0] per_q;     // position within the current tone period
    logic        ch_q;
    logic        busy_q;
    logic        done_q;

    // Next-state values.
    state_t      state_d;
    logic [2:0]  note_d;
    logic [23:0] dur_d;
    logic [15:0] per_d;
    logic        ch_d;
    logic        busy_d;
    logic        done_d;

    logic        note_end;  // current note (including its gap) is finished
    logic [15:0] cur_per;   // period of the note now playing
    logic [15:0] nxt_per;   // period of the note selected for the next cycle

    assign cur_per = period_of(note_q);
    assign nxt_per = period_of(note_d);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        dur_d    = dur_q;
        per_d    = per_q;
        done_d   = 1'b0;
        note_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (bus.start && !bus.stop) begin
                    state_d = ST_PLAY;
                    note_d  = 3'd0;
                    dur_d   = 24'd0;
                    per_d   = 16'd0;
                end
            end

            ST_PLAY: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    dur_d   = 24'd0;
                    per_d   = 16'd0;
                end else if (dur_q == DUR_M1) begin
                    if (GAP == 0) begin
                        note_end = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        dur_d   = 24'd0;
                        per_d   = 16'd0;
                    end
                end else begin
                    dur_d = dur_q + 24'd1;
                    // Wrap at P-1. A rest (P=0) keeps the counter at 0.
                    if (cur_per == 16'd0 || per_q == cur_per - 16'd1) begin
                        per_d = 16'd0;
                    end else begin
                        per_d = per_q + 16'd1;
                    end
                end
            end

            ST_GAP: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    dur_d   = 24'd0;
                end else if (dur_q == GAP_M1) begin
                    note_end = 1'b1;
                end else begin
                    dur_d = dur_q + 24'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dur_d   = 24'd0;
                per_d   = 16'd0;
            end
        endcase

        // Advance to the next note, or finish the melody.
        if (note_end) begin
            dur_d = 24'd0;
            per_d = 16'd0;
            if (note_q == LAST_IDX) begin
                done_d = 1'b1;
`ifdef MELODY_LOOP_EN
                state_d = ST_PLAY;
                note_d  = 3'd0;
`else
                state_d = ST_IDLE;
`endif
            end else begin
                state_d = ST_PLAY;
                note_d  = note_q + 3'd1;
            end
        end

        // Outputs are produced from the next-cycle state, so the registered
        // ch_out matches the period counter that is held alongside it.
        busy_d = (state_d != ST_IDLE);
        ch_d   = (state_d == ST_PLAY) && (per_d < (nxt_per >> 1));
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            note_q  <= 3'd0;
            dur_q   <= 24'd0;
            per_q   <= 16'd0;
            ch_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            per_q   <= per_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ch_out    = ch_q;
    assign bus.busy      = busy_q;
    assign bus.note_idx  = note_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_melody_player.sv
// -----------------------------------------------------------------------------
// tb_melody_player
//
// Runs three player instances side by side on one clock and one reset:
//   u_short : DUR=20,    GAP=1,   LEN=3  (one-cycle gaps)
//   u_nogap : DUR=2,     GAP=0,   LEN=8  (shortest notes, whole table, no gap)
//   u_long  : DUR=46000, GAP=100, LEN=1  (full tone period, waveform and gap)
// The two short instances get random start/stop traffic. The long instance
// follows a script: a full play, an ignored start, a stop, start+stop together,
// and an async reset in the middle of a note.
//
// The reference model tracks the time elapsed since start. From that it derives
// note index, tone phase, gap and end of melody with plain arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_melody_player;

    localparam int N_INST = 3;
    localparam int N_CYC  = 60000;
    localparam int RST_AT = 55000;

    localparam int P_DUR [N_INST] = '{20, 2, 46000};
    localparam int P_GAP [N_INST] = '{1, 0, 100};
    localparam int P_LEN [N_INST] = '{3, 8, 1};

    localparam int PERIOD [8] = '{45872, 40863, 36404, 34361,
                                  30612, 27273, 24297, 22933};

`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    melody_if bus_s ();
    melody_if bus_g ();
    melody_if bus_l ();

    melody_player #(.DUR(P_DUR[0]), .GAP(P_GAP[0]), .LEN(P_LEN[0])) u_short (
        .clk (clk), .rstn(rstn), .bus (bus_s)
    );
    melody_player #(.DUR(P_DUR[1]), .GAP(P_GAP[1]), .LEN(P_LEN[1])) u_nogap (
        .clk (clk), .rstn(rstn), .bus (bus_g)
    );
    melody_player #(.DUR(P_DUR[2]), .GAP(P_GAP[2]), .LEN(P_LEN[2])) u_long (
        .clk (clk), .rstn(rstn), .bus (bus_l)
    );

    // ---------------- scoreboard state ----------------
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_now  = 0;

    logic st [N_INST];
    logic sp [N_INST];

    // Reference model: playing flag, cycles since start, held index, done flag.
    bit m_play [N_INST];
    int m_t    [N_INST];
    int m_hold [N_INST];
    bit m_done [N_INST];

    function automatic int slot_of(int i);
        return P_DUR[i] + P_GAP[i];
    endfunction

    function automatic int melody_time(int i);
        if (LOOP) return m_t[i] % (slot_of(i) * P_LEN[i]);
        return m_t[i];
    endfunction

    // Expected {busy, done, ch_out, note_idx} for the current model state.
    function automatic logic [5:0] m_out(int i);
        int tt, nt, w, p;
        logic ch, dn;
        if (!m_play[i]) return {1'b0, m_done[i], 1'b0, 3'(m_hold[i])};
        tt = melody_time(i);
        nt = tt / slot_of(i);
        w  = tt % slot_of(i);
        p  = PERIOD[nt];
        ch = (w < P_DUR[i]) && (p != 0) && ((w % p) < (p / 2));
        dn = LOOP && (m_t[i] > 0) && (tt == 0);
        return {1'b1, dn, ch, 3'(nt)};
    endfunction

    task automatic model_step(int i, logic s_start, logic s_stop);
        if (!rstn) begin
            m_play[i] = 1'b0; m_t[i] = 0; m_hold[i] = 0; m_done[i] = 1'b0;
        end else if (!m_play[i]) begin
            m_done[i] = 1'b0;
            if (s_start && !s_stop) begin
                m_play[i] = 1'b1;
                m_t[i]    = 0;
            end
        end else if (s_stop) begin
            m_hold[i] = melody_time(i) / slot_of(i);
            m_play[i] = 1'b0;
            m_done[i] = 1'b0;
        end else begin
            m_t[i]++;
            if (!LOOP && m_t[i] == slot_of(i) * P_LEN[i]) begin
                m_play[i] = 1'b0;
                m_hold[i] = P_LEN[i] - 1;
                m_done[i] = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        bus_s.start = st[0]; bus_s.stop = sp[0];
        bus_g.start = st[1]; bus_g.stop = sp[1];
        bus_l.start = st[2]; bus_l.stop = sp[2];
    endtask

    // One clock: the model sees the same inputs the DUTs sample at the edge,
    // and the expected outputs for the following cycle go into the queue.
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < N_INST; i++) model_step(i, st[i], sp[i]);
        exp_q.push_back({m_out(2), m_out(1), m_out(0)});
        @(negedge clk);
    endtask

    task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d busy/done/ch/idx got=%b_%b_%b_%0d exp=%b_%b_%b_%0d",
                     name, cyc_now, got[5], got[4], got[3], got[2:0],
                     exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    function automatic logic [5:0] pack_s();
        return {bus_s.busy, bus_s.done, bus_s.ch_out, bus_s.note_idx};
    endfunction
    function automatic logic [5:0] pack_g();
        return {bus_g.busy, bus_g.done, bus_g.ch_out, bus_g.note_idx};
    endfunction
    function automatic logic [5:0] pack_l();
        return {bus_l.busy, bus_l.done, bus_l.ch_out, bus_l.note_idx};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [17:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check6("short", pack_s(), e[5:0]);
            check6("nogap", pack_g(), e[11:6]);
            check6("long",  pack_l(), e[17:12]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N_INST; i++) begin
            st[i] = 1'b0; sp[i] = 1'b0;
            m_play[i] = 1'b0; m_t[i] = 0; m_hold[i] = 0; m_done[i] = 1'b0;
        end
        apply_inputs();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            cyc_now = cyc;
            if (cyc == 3) rstn = 1'b1;

            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 15) == 0);
                sp[i] = ($urandom_range(0, 99) == 0);
            end
            // Long instance: full play, ignored start while busy, restart,
            // stop mid-note, start+stop together, restart, reset mid-note,
            // restart after reset.
            st[2] = (cyc == 10) || (cyc == 20000) || (cyc == 46200) ||
                    (cyc == 50000) || (cyc == 50100) || (cyc == 56000);
            sp[2] = (cyc == 48000) || (cyc == 50000);
            apply_inputs();

            if (cyc == RST_AT) begin
                // The clock is low here, so the outputs can only clear through
                // the asynchronous reset path.
                #1 rstn = 1'b0;
                #1;
                check6("async_rst_short", pack_s(), 6'd0);
                check6("async_rst_nogap", pack_g(), 6'd0);
                check6("async_rst_long",  pack_l(), 6'd0);
            end
            if (cyc == RST_AT + 3) rstn = 1'b1;

            cycle();
        end

        st = '{default: 1'b0};
        sp = '{default: 1'b0};
        apply_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter DUR, default 12000000, note duration in clk cycles (1 s at 12 MHz), legal range 2..2^24-1.
REQ-002 Parameter GAP, default 600000, silence after each note in clk cycles, legal range 0..2^24-1; 0 means no gap.
REQ-003 Parameter LEN, default 8, number of notes played from the table, legal range 1..8.
REQ-004 clk  input  1  system clock (12 MHz board clock).
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  synchronous request to begin playback.
REQ-007 stop  input  1  synchronous abort of playback.
REQ-008 ch_out  output  1  square-wave audio output, registered.
REQ-009 busy  output  1  high while in PLAY or GAP.
REQ-010 note_idx  output  3  index of the current table entry.
REQ-011 done  output  1  one-cycle pulse at melody end.

Function
REQ-012 The block SHALL hold an 8-entry, 16-bit period table indexed 0..7, built from divider.vh constants: DO_4, RE_4, MI_4, FA_4, SOL_4, LA_4, SI_4, DO_5.
REQ-013 The block SHALL implement the FSM states IDLE, PLAY and GAP.
REQ-014 IDLE: start=1 and stop=0 SHALL give, on the next edge: PLAY, note_idx=0, duration counter=0, period counter=0.
REQ-015 PLAY: the period counter SHALL count 0..P-1 and wrap; ch_out SHALL be 1 while the count is below P/2 (P>>1) and 0 otherwise.
REQ-016 A table entry of P=0 SHALL be a rest: ch_out held at 0 for the full note.
REQ-017 PLAY SHALL last exactly DUR cycles, counted by a 24-bit duration counter; GAP (or PLAY of the next note when GAP=0) SHALL follow.
REQ-018 GAP SHALL hold ch_out=0 for exactly GAP cycles, then increment note_idx and enter PLAY with both counters cleared.
REQ-019 Last note (note_idx=LEN-1) end of GAP, or end of PLAY when GAP=0, SHALL: pulse done for one cycle, enter IDLE, keep note_idx at LEN-1.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 stop=1 in PLAY or GAP SHALL, on the next edge: enter IDLE, ch_out=0, busy=0; done SHALL NOT pulse.
REQ-022 stop and start asserted in the same cycle SHALL resolve stop-wins; the FSM stays in or returns to IDLE.
REQ-023 In IDLE, ch_out SHALL be 0 and busy SHALL be 0.
REQ-024 Every output SHALL come directly from a flop, with no combinational path from any input to any output.

Reset
REQ-025 rstn=0 SHALL immediately force: IDLE, ch_out=0, busy=0, done=0, note_idx=0, all counters 0.
REQ-026 rstn asserted mid-note SHALL abort playback without a done pulse; after release, the block waits for start.

Configuration
REQ-027 Macro MELODY_LOOP_EN defined: at melody end the block SHALL pulse done, set note_idx=0 and re-enter PLAY (continuous loop) until stop or reset.
REQ-028 MELODY_LOOP_EN undefined: melody end SHALL follow REQ-019 (single shot).

Verification (DUR=100000, GAP=1000, LEN=3)
REQ-029 Reset, then start pulse -> busy=1 next cycle; note_idx 0,1,2 each for 101000 cycles; done pulses once at cycle 303000; busy=0 after.
REQ-030 PLAY of note 0 -> ch_out period 45872 cycles, high for 22936 cycles; during GAP, ch_out=0 for exactly 1000 cycles.
REQ-031 stop at cycle 150000 -> IDLE, ch_out=0, busy=0 next cycle, no done pulse; a new start then replays from note_idx=0.
REQ-032 start and stop high in the same cycle from IDLE -> busy stays 0; start pulse during PLAY -> note timing unchanged.
REQ-033 rstn pulsed low at cycle 50000 -> all outputs 0 asynchronously; playback does not resume until start.
REQ-034 MELODY_LOOP_EN defined -> done pulses at cycles 303000 and 606000; note_idx sequence 0,1,2,0,1,2 continues without a gap in busy.
